bcd_time_counter: RTL and testbench

//   24-hour BCD time-of-day counter with a built-in one-second prescaler.

---
 rtl/bcd_time_counter.sv | 142 ++++++++++++++
 tb/tb_bcd_time_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   24-hour BCD time-of-day counter with a built-in one-second prescaler,
//   a 12/24-hour display mode and a key-driven set mode (hours, then minutes).
//   Drives the six display digits; key pulses come from the key scanner.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   en                  prescaler enable (low freezes the prescaler)
//   key_mode            pulse: RUN -> SET_H -> SET_M -> RUN
//   key_up              pulse: increment the selected field in SET_H / SET_M
//   mode_toggle         pulse: flip 12/24-hour display mode
//   second_0/1, minute_0/1, hour_0/1   BCD digits (hour formatted per mode)
//   pm                  internal hour >= 12
//   mode_24h            current display mode
//   set_state           00 RUN, 01 SET_H, 10 SET_M
//   tick                1-cycle pulse with each second advance
//   day_wrap            1-cycle pulse on 23:59:59 -> 00:00:00
module bcd_time_counter #(
  parameter int unsigned CLK_DIV          = 50_000_000,
  parameter bit          MODE_24H_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       mode_toggle,
  output logic [3:0] second_0,
  output logic [3:0] second_1,
  output logic [3:0] minute_0,
  output logic [3:0] minute_1,
  output logic [3:0] hour_0,
  output logic [3:0] hour_1,
  output logic       pm,
  output logic       mode_24h,
  output logic [1:0] set_state,
  output logic       tick,
  output logic       day_wrap
);

  localparam int unsigned   PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] SET_H = 2'b01;
  localparam logic [1:0] SET_M = 2'b10;

  logic [1:0]    state, state_nx;
  logic [PW-1:0] presc;
  logic [7:0]    sec, min, hr;   // {tens, units} BCD, hour always 24 h internally

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Second advance only happens while running; set keys only in their state.
  // key_mode has priority, so a simultaneous key_up is dropped.
  logic adv, up_ok, s_wrap, m_wrap, h_wrap, inc_m, inc_h, clr_s;
  assign adv    = (state == RUN) && en && (presc == LAST);
  assign up_ok  = key_up && !key_mode;
  assign s_wrap = (sec == 8'h59);
  assign m_wrap = (min == 8'h59);
  assign h_wrap = (hr == 8'h23);
  assign inc_m  = (adv && s_wrap) || (state == SET_M && up_ok);
  assign inc_h  = (adv && s_wrap && m_wrap) || (state == SET_H && up_ok);
  assign clr_s  = (state == SET_M) && key_mode;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // FSM next state; the unused encoding falls back to RUN
  always_comb begin
    state_nx = RUN;
    case (state)
      RUN:     state_nx = key_mode ? SET_H : RUN;
      SET_H:   state_nx = key_mode ? SET_M : SET_H;
      SET_M:   state_nx = key_mode ? RUN   : SET_M;
      default: state_nx = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    set_state = state;
  end

  // Prescaler, time registers, registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sec      <= 8'h00;
      min      <= 8'h00;
      hr       <= 8'h00;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
      mode_24h <= MODE_24H_DEFAULT;
    end else begin
      // held at 0 outside RUN, so leaving SET_M restarts a full second
      if (state != RUN)       presc <= '0;
      else if (en)            presc <= (presc == LAST) ? '0 : presc + 1'b1;
      if (clr_s)              sec <= 8'h00;
      else if (adv)           sec <= bcd_inc(sec, 8'h59);
      if (inc_m)              min <= bcd_inc(min, 8'h59);
      if (inc_h)              hr  <= bcd_inc(hr, 8'h23);
      tick     <= adv;
      day_wrap <= adv && s_wrap && m_wrap && h_wrap;
      mode_24h <= mode_24h ^ mode_toggle;
    end
  end

  assign second_0 = sec[3:0];
  assign second_1 = sec[7:4];
  assign minute_0 = min[3:0];
  assign minute_1 = min[7:4];

  // Display formatting: 24 h passes through, 12 h maps 0->12 and 13..23->1..11
  logic [4:0] hbin, h12;
  assign hbin = 5'(hr[7:4]) * 5'd10 + 5'(hr[3:0]);
  assign pm   = (hbin >= 5'd12);

  always_comb begin
    h12    = hbin;
    hour_1 = hr[7:4];
    hour_0 = hr[3:0];
    if (hbin == 5'd0)       h12 = 5'd12;
    else if (hbin > 5'd12)  h12 = hbin - 5'd12;
    if (!mode_24h) begin
      if (h12 >= 5'd10) begin
        hour_1 = 4'd1;
        hour_0 = 4'(h12 - 5'd10);
      end else begin
        hour_1 = 4'd0;
        hour_0 = 4'(h12);
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst, en, key_mode, key_up, mode_toggle;
  logic [3:0] second_0, second_1, minute_0, minute_1, hour_0, hour_1;
  logic       pm, mode_24h, tick, day_wrap;
  logic [1:0] set_state;

  int n_run  = 0;
  int n_fail = 0;
  int dw_cnt = 0;

  bcd_time_counter #(.CLK_DIV(4), .MODE_24H_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .key_mode(key_mode), .key_up(key_up),
    .mode_toggle(mode_toggle), .second_0(second_0), .second_1(second_1),
    .minute_0(minute_0), .minute_1(minute_1), .hour_0(hour_0), .hour_1(hour_1),
    .pm(pm), .mode_24h(mode_24h), .set_state(set_state), .tick(tick),
    .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (day_wrap === 1'b1) dw_cnt++;

  function automatic logic [23:0] tod();
    return {hour_1, hour_0, minute_1, minute_0, second_1, second_0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // starts and ends on a negedge
  task automatic pulse(input logic km, input logic ku, input logic mt);
    key_mode = km; key_up = ku; mode_toggle = mt;
    @(negedge clk);
    key_mode = 1'b0; key_up = 1'b0; mode_toggle = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // negedges until tick is seen (inclusive)
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      n++;
      if (tick) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  int n, bad, dw0;

  initial begin
    rst = 1'b1; en = 1'b0; key_mode = 1'b0; key_up = 1'b0; mode_toggle = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_time", tod(), 24'h000000);
    chk("rst_state", set_state, 2'b00);
    chk("rst_tick", tick, 1'b0);
    chk("rst_dw", day_wrap, 1'b0);
    chk("rst_mode", mode_24h, 1'b1);
    chk("rst_pm", pm, 1'b0);

    // free run: 60 ticks, 4 cycles apart
    rst = 1'b0; en = 1'b1;
    dw0 = dw_cnt; bad = 0;
    for (int i = 0; i < 60; i++) begin
      wait_tick(n);
      if (n != 4) bad++;
    end
    chk("tick_period", bad, 0);
    chk("run60_time", tod(), 24'h000100);
    chk("run60_dw", dw_cnt - dw0, 0);
    @(negedge clk);
    chk("tick_1cyc", tick, 1'b0);

    // set 23:59 then roll over the day
    do_reset();
    pulse(1, 0, 0);
    chk("seth_state", set_state, 2'b01);
    repeat (23) pulse(0, 1, 0);
    chk("seth_23", tod(), 24'h230000);
    pulse(1, 0, 0);
    chk("setm_state", set_state, 2'b10);
    repeat (59) pulse(0, 1, 0);
    chk("setm_59", tod(), 24'h235900);
    pulse(1, 0, 0);
    chk("back_run", set_state, 2'b00);
    dw0 = dw_cnt; bad = 0;
    for (int i = 0; i < 59; i++) begin
      wait_tick(n);
      if (n != 4) bad++;
    end
    chk("pre_wrap_period", bad, 0);
    chk("pre_wrap_time", tod(), 24'h235959);
    chk("pre_wrap_dw", dw_cnt - dw0, 0);
    wait_tick(n);
    chk("wrap_period", n, 4);
    chk("wrap_time", tod(), 24'h000000);
    chk("wrap_dw", day_wrap, 1'b1);
    chk("wrap_tick", tick, 1'b1);
    @(negedge clk);
    chk("wrap_dw_drop", day_wrap, 1'b0);
    chk("wrap_dw_once", dw_cnt - dw0, 1);

    // 12-hour formatting, driven from SET_H so the time is frozen
    do_reset();
    dw0 = dw_cnt;
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("m12_mode", mode_24h, 1'b0);
    chk("m12_h00", {hour_1, hour_0}, 8'h12);
    chk("m12_pm00", pm, 1'b0);
    repeat (12) pulse(0, 1, 0);
    chk("m12_h12", {hour_1, hour_0}, 8'h12);
    chk("m12_pm12", pm, 1'b1);
    pulse(0, 1, 0);
    chk("m12_h13", tod(), 24'h010000);
    chk("m12_pm13", pm, 1'b1);
    pulse(0, 0, 1);
    chk("m24_mode", mode_24h, 1'b1);
    chk("m24_h13", tod(), 24'h130000);
    chk("m24_pm13", pm, 1'b1);
    pulse(0, 1, 1);                      // toggle and increment together: 14 -> 02
    chk("m12_h14", {hour_1, hour_0}, 8'h02);
    repeat (10) pulse(0, 1, 0);          // 14 + 10 wraps 23 -> 00
    chk("m12_hwrap", {hour_1, hour_0, pm}, {8'h12, 1'b0});
    pulse(0, 0, 1);
    chk("seth_wrap", tod(), 24'h000000);
    chk("seth_no_dw", dw_cnt - dw0, 0);

    // minutes wrap without hour carry, key priority, key_up in RUN
    pulse(1, 0, 0);
    repeat (59) pulse(0, 1, 0);
    chk("setm_59b", tod(), 24'h005900);
    pulse(0, 1, 0);
    chk("setm_wrap", tod(), 24'h000000);
    repeat (25) pulse(0, 1, 0);
    pulse(1, 1, 0);
    chk("prio_state", set_state, 2'b00);
    chk("prio_time", tod(), 24'h002500);
    pulse(0, 1, 0);
    chk("run_up_ign", tod(), 24'h002500);
    pulse(1, 1, 0);
    chk("prio2_state", set_state, 2'b01);
    chk("prio2_time", tod(), 24'h002500);

    // reset from SET_M in 12 h mode
    repeat (10) pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    chk("pre_rst", {set_state, mode_24h, tod()}, {2'b10, 1'b0, 24'h102500});
    do_reset();
    chk("mid_rst_time", tod(), 24'h000000);
    chk("mid_rst_state", set_state, 2'b00);
    chk("mid_rst_tick", tick, 1'b0);
    chk("mid_rst_mode", mode_24h, 1'b1);

    // en low for 10 cycles mid-prescale
    wait_tick(n);
    chk("en_first", n, 4);
    chk("en_t1", tod(), 24'h000001);
    repeat (2) @(negedge clk);
    en = 1'b0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tod() != 24'h000001 || tick) bad++;
    end
    en = 1'b1;
    chk("en_hold", bad, 0);
    wait_tick(n);
    chk("en_resume", n, 2);
    chk("en_t2", tod(), 24'h000002);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
